fp_div_round_pack: RTL and testbench



---
 rtl/fp_div_pkg.sv | 36 +++
 rtl/fp_rne_round.sv | 26 ++
 rtl/fp_div_round_pack.sv | 135 +++++++++++++
 tb/tb_fp_div_round_pack.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the FP32 divider back end.
package fp_div_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    ZERO   = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp_class_e;

  localparam int unsigned SIG_W   = 24;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned QUOT_W  = 27;
  localparam int unsigned FLAGS_W = 4;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int unsigned FLAG_INVALID   = 3;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_INEXACT   = 0;

  // Normalised significand plus rounding bits carried from stage 1 to stage 2.
  typedef struct packed {
    logic              sign;
    fp_class_e         cls;
    logic [SIG_W-1:0]  sig;
    logic              g;
    logic              r;
    logic              s;
  } s1_payload_t;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even of a 24-bit significand with guard/round/sticky bits.
module fp_rne_round
  import fp_div_pkg::*;
(
  input  logic [SIG_W-1:0]  sig,
  input  logic              g,
  input  logic              r,
  input  logic              s,
  output logic [FRAC_W-1:0] frac_c,
  output logic              carry_c,
  output logic              inexact_c
);

  logic inc;
  logic frac_co;

  // Increment only the fraction; a carry out of it overflows the significand
  // exactly when the hidden bit is already set.
  always_comb begin
    inc                = g & (r | s | sig[0]);
    {frac_co, frac_c}  = {1'b0, sig[FRAC_W-1:0]} + (FRAC_W+1)'(inc);
    carry_c            = frac_co & sig[SIG_W-1];
    inexact_c          = g | r | s;
  end

endmodule

// File: rtl/fp_div_round_pack.sv
// FP32 divider back end: normalise, round-to-nearest-even and pack, two pipeline stages.
module fp_div_round_pack
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 10,
  parameter int FTZ   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic signed [EXP_W-1:0]  in_exp,
  input  logic [QUOT_W-1:0]        in_quot,
  input  logic                     in_sticky,
  input  logic [1:0]               in_class,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [FLAGS_W-1:0]       out_flags
);

  // Two guard bits absorb the -1 normalise and +1 rounding adjustments.
  localparam int unsigned XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_TOP  = XW'(EXP_MAX);
  localparam logic signed [XW-1:0] EXP_ZERO = XW'(0);

  if (FTZ != 1) begin : g_ftz_check
    $error("fp_div_round_pack: only FTZ=1 is supported");
  end

  logic                    s1_valid;
  s1_payload_t             s1_q;
  s1_payload_t             s1_d;
  logic signed [XW-1:0]    s1_exp;
  logic signed [XW-1:0]    exp_norm;
  logic [QUOT_W-1:0]       norm;
  logic                    s1_load;
  logic                    s2_load;

  logic [FRAC_W-1:0]       frac_rnd;
  logic                    carry;
  logic                    inexact;
  logic signed [XW-1:0]    exp_rnd;
  logic [31:0]             res_d;
  logic [FLAGS_W-1:0]      flags_d;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Stage 1: bring the quotient into [1,2) and split off the rounding bits.
  always_comb begin
    norm     = in_quot;
    exp_norm = XW'(in_exp);
    if (!in_quot[QUOT_W-1]) begin
      norm     = {in_quot[QUOT_W-2:0], 1'b0};
      exp_norm = XW'(in_exp) - XW'(1);
    end
    s1_d.sign = in_sign;
    s1_d.cls  = fp_class_e'(in_class);
    s1_d.sig  = norm[QUOT_W-1:3];
    s1_d.g    = norm[2];
    s1_d.r    = norm[1];
    s1_d.s    = norm[0] | in_sticky;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s1_exp   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q   <= s1_d;
        s1_exp <= exp_norm;
      end
    end
  end

  fp_rne_round u_round (
    .sig       (s1_q.sig),
    .g         (s1_q.g),
    .r         (s1_q.r),
    .s         (s1_q.s),
    .frac_c    (frac_rnd),
    .carry_c   (carry),
    .inexact_c (inexact)
  );

  // Stage 2: range check after rounding, then class overrides win.
  always_comb begin
    res_d   = '0;
    flags_d = '0;
    exp_rnd = s1_exp + (carry ? XW'(1) : XW'(0));
    case (s1_q.cls)
      NAN: begin
        res_d                 = QNAN;
        flags_d[FLAG_INVALID] = 1'b1;
      end
      ZERO: res_d = {s1_q.sign, 31'h0};
      INF:  res_d = {s1_q.sign, 8'hFF, 23'h0};
      default: begin
        if (exp_rnd >= EXP_TOP) begin
          res_d                  = {s1_q.sign, 8'hFF, 23'h0};
          flags_d[FLAG_OVERFLOW] = 1'b1;
          flags_d[FLAG_INEXACT]  = 1'b1;
        end else if (exp_rnd <= EXP_ZERO) begin
          res_d                   = {s1_q.sign, 31'h0};
          flags_d[FLAG_UNDERFLOW] = 1'b1;
          flags_d[FLAG_INEXACT]   = 1'b1;
        end else begin
          res_d                 = {s1_q.sign, exp_rnd[7:0], frac_rnd};
          flags_d[FLAG_INEXACT] = inexact;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res_d;
        out_flags  <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_div_round_pack.sv
// Self-checking bench for fp_div_round_pack: directed table, stall/reset sequences, random stream.
module tb_fp_div_round_pack;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               in_sign;
  logic signed [9:0]  in_exp;
  logic [26:0]        in_quot;
  logic               in_sticky;
  logic [1:0]         in_class;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_result;
  logic [3:0]         out_flags;

  fp_div_round_pack #(.EXP_W(10), .FTZ(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_quot    (in_quot),
    .in_sticky  (in_sticky),
    .in_class   (in_class),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_out    = 0;
  bit chk_lat  = 0;
  bit last_acc;
  bit last_in_ready;
  bit stall_prev = 0;
  logic [35:0] held;
  logic [35:0] next_exp;
  logic [35:0] exp_q[$];
  int          acc_q[$];

  typedef struct {
    logic        sign;
    int          e;
    logic [26:0] quot;
    logic        sticky;
    logic [1:0]  cls;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  // Reference: value-level division result rounding, independent of bit slicing.
  function automatic logic [35:0] model(input logic sgn, input int e_in, input logic [26:0] quot,
                                        input logic st, input logic [1:0] cls);
    int unsigned q;
    int unsigned m;
    int unsigned rem;
    int          e;
    bit          up;
    bit          inex;
    if (cls == 2'd3) return {32'h7FC0_0000, 4'b1000};
    if (cls == 2'd1) return {sgn, 31'h0, 4'b0000};
    if (cls == 2'd2) return {sgn, 8'hFF, 23'h0, 4'b0000};
    q = quot;
    e = e_in;
    if (q < (1 << 26)) begin
      q = q * 2;
      e = e - 1;
    end
    m    = q / 8;
    rem  = q % 8;
    inex = (rem != 0) || st;
    if (rem > 4 || (rem == 4 && st)) up = 1;
    else if (rem == 4)               up = (m % 2) == 1;
    else                             up = 0;
    m = m + (up ? 1 : 0);
    if (m == (1 << 24)) begin
      m = m / 2;
      e = e + 1;
    end
    if (e >= 255) return {sgn, 8'hFF, 23'h0, 4'b0101};
    if (e <= 0)   return {sgn, 31'h0, 4'b0011};
    return {sgn, 8'(e), 23'(m - (1 << 23)), 3'b000, inex};
  endfunction

  // One cycle: settle, score transfers, advance to the next falling edge.
  task automatic tick();
    logic [35:0] e;
    int          a;
    #1;
    last_acc      = 0;
    last_in_ready = in_ready;
    if (!rst) begin
      if (stall_prev) chk("stall_hold", {27'h0, out_valid, out_result, out_flags}, {28'h1, held});
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("spurious_out", {28'h0, out_result, out_flags}, 64'h0);
          if ({out_result, out_flags} == 36'h0) chk("spurious_valid", 64'(out_valid), 64'h0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("result", {28'h0, out_result, out_flags}, {28'h0, e});
          if (chk_lat) chk("latency", 64'(cyc - a), 64'd2);
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_result, out_flags};
      if (in_valid && in_ready) begin
        exp_q.push_back(next_exp);
        acc_q.push_back(cyc);
        last_acc = 1;
      end
    end else begin
      stall_prev = 0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_op(input logic sgn, input int e, input logic [26:0] quot,
                        input logic st, input logic [1:0] cls);
    in_sign   = sgn;
    in_exp    = 10'(e);
    in_quot   = quot;
    in_sticky = st;
    in_class  = cls;
  endtask

  task automatic rand_op();
    int   e;
    int   r;
    logic [1:0] c;
    e = int'($urandom_range(400, 0)) - 60;
    r = int'($urandom_range(9, 0));
    c = (r < 7) ? 2'd0 : 2'(r - 6);
    set_op(1'($urandom), e, 27'($urandom_range(27'h7FFFFFF, 27'h2000000)), 1'($urandom), c);
    next_exp = model(in_sign, e, in_quot, in_sticky, in_class);
  endtask

  task automatic drain(input string name);
    int n = 0;
    in_valid  = 0;
    out_ready = 1;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bit rdy_pat[10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    int sent;
    int out_base;

    tbl[0]  = '{0, 127, 27'h4000000, 0, 2'd0, 32'h3F80_0000, 4'b0000};
    tbl[1]  = '{0, 126, 27'h2AAAAAA, 1, 2'd0, 32'h3EAA_AAAB, 4'b0001};
    tbl[2]  = '{0, 127, 27'h2AAAAAA, 1, 2'd0, 32'h3F2A_AAAB, 4'b0001};
    tbl[3]  = '{0, 127, 27'h7FFFFFC, 0, 2'd0, 32'h4000_0000, 4'b0001};
    tbl[4]  = '{0, 256, 27'h4000000, 0, 2'd0, 32'h7F80_0000, 4'b0101};
    tbl[5]  = '{1, 0,   27'h4000000, 0, 2'd0, 32'h8000_0000, 4'b0011};
    tbl[6]  = '{0, 127, 27'h4000000, 0, 2'd3, 32'h7FC0_0000, 4'b1000};
    tbl[7]  = '{1, 200, 27'h4000000, 1, 2'd1, 32'h8000_0000, 4'b0000};
    tbl[8]  = '{1, 10,  27'h5000000, 0, 2'd2, 32'hFF80_0000, 4'b0000};
    tbl[9]  = '{0, 1,   27'h2000000, 0, 2'd0, 32'h0000_0000, 4'b0011};
    tbl[10] = '{0, 254, 27'h7FFFFFC, 0, 2'd0, 32'h7F80_0000, 4'b0101};
    tbl[11] = '{0, 254, 27'h4000000, 0, 2'd0, 32'h7F00_0000, 4'b0000};
    tbl[12] = '{0, 127, 27'h4000004, 0, 2'd0, 32'h3F80_0000, 4'b0001};

    rst       = 1;
    in_valid  = 0;
    out_ready = 1;
    set_op(0, 0, 27'h0, 0, 2'd0);
    next_exp  = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_result", 64'(out_result), 64'd0);
    chk("reset_out_flags", 64'(out_flags), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, one at a time so latency is observable.
    chk_lat = 1;
    for (int i = 0; i < 13; i++) begin
      set_op(tbl[i].sign, tbl[i].e, tbl[i].quot, tbl[i].sticky, tbl[i].cls);
      next_exp  = {tbl[i].res, tbl[i].flg};
      in_valid  = 1;
      out_ready = 1;
      tick();
      chk("table_accept", 64'(last_acc), 64'd1);
      drain("table");
    end
    chk_lat = 0;

    // Four back-to-back ops with a two-cycle downstream stall.
    sent     = 0;
    out_base = n_out;
    for (int t = 0; t < 10; t++) begin
      out_ready = rdy_pat[t];
      in_valid  = (sent < 4);
      rand_op();
      in_class  = 2'd0;
      next_exp  = model(in_sign, int'(in_exp), in_quot, in_sticky, in_class);
      tick();
      if (last_acc) sent++;
      if (t == 2 || t == 3) chk("stall_in_ready", 64'(last_in_ready), 64'd0);
      if (t == 0 || t == 1 || t == 4) chk("flow_in_ready", 64'(last_in_ready), 64'd1);
    end
    drain("stream");
    chk("stream_count", 64'(n_out - out_base), 64'd4);

    // Reset with two ops in flight discards them.
    out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1;
      rand_op();
      tick();
    end
    in_valid = 0;
    rst      = 1;
    tick();
    rst = 0;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("rst_flush_out_valid", 64'(out_valid), 64'd0);
    chk("rst_flush_in_ready", 64'(in_ready), 64'd1);
    out_base = n_out;
    for (int k = 0; k < 5; k++) tick();
    chk("rst_no_stale", 64'(n_out - out_base), 64'd0);

    // Random stream with random backpressure against the reference model.
    for (int k = 0; k < 500; k++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(3, 0) != 0);
      rand_op();
      tick();
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
